// File: rtl/network_mmio_pkg.sv
// network_mmio_pkg: shared FSM states, register offsets and status bit positions
package network_mmio_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [7:0] CTRL_ADDR = 8'h00;
  localparam logic [7:0] CYCLES_ADDR = 8'h01;
  localparam logic [7:0] IN_BASE = 8'h10;
  localparam int START_BIT = 0;
  localparam int CLEAR_BIT = 1;
  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;
  localparam int ERR_BIT = 2;
  localparam int TO_BIT = 3;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return v == '1 ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/network_mmio_regbank.sv
// network_mmio_regbank: chunked operand/result storage and the read mux over it
module network_mmio_regbank
  import network_mmio_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_OUT = 2,
  parameter int WORD_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              addr,
  input  logic                    write,
  input  logic [31:0]             wdata,
  input  logic                    capture,
  input  logic [N_OUT*WORD_W-1:0] cap_data,
  output logic [N_IN*WORD_W-1:0]  in_data,
  output logic [31:0]             rd_data,
  output logic                    in_hit
);
  localparam int CH = WORD_W / 32;
  localparam int NI = N_IN * CH;
  localparam int NO = N_OUT * CH;
  logic [31:0] in_mem [NI];
  logic [31:0] out_mem [NO];
  int off;
  assign off = int'(addr) - int'(IN_BASE);
  assign in_hit = off >= 0 && off < NI;
  // Input chunks take bus writes; output chunks take a whole result bundle on capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NI; n++) in_mem[n] <= '0;
      for (int n = 0; n < NO; n++) out_mem[n] <= '0;
    end else begin
      for (int n = 0; n < NI; n++) if (write && off == n) in_mem[n] <= wdata;
      if (capture)
        for (int n = 0; n < NO; n++) out_mem[n] <= cap_data[(N_OUT-1-n/CH)*WORD_W + (n%CH)*32 +: 32];
    end
  end
  for (genvar g = 0; g < NI; g++) begin : g_pack
    assign in_data[(N_IN-1-g/CH)*WORD_W + (g%CH)*32 +: 32] = in_mem[g];
  end
  // Read mux over both windows; anything outside them reads as zero.
  always_comb begin
    rd_data = '0;
    for (int n = 0; n < NI; n++) if (off == n) rd_data = in_mem[n];
    for (int n = 0; n < NO; n++) if (off == NI + n) rd_data = out_mem[n];
  end
endmodule

// File: rtl/network_mmio_bridge.sv
// network_mmio_bridge: Avalon-MM register front end that issues operands to a core and captures its results
module network_mmio_bridge
  import network_mmio_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_OUT = 2,
  parameter int WORD_W = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              avs_s0_address,
  input  logic                    avs_s0_read,
  input  logic                    avs_s0_write,
  input  logic [31:0]             avs_s0_writedata,
  output logic [31:0]             avs_s0_readdata,
  output logic                    avs_s0_readdatavalid,
  output logic                    core_in_valid,
  input  logic                    core_in_ready,
  output logic [N_IN*WORD_W-1:0]  core_in_data,
  input  logic                    core_out_valid,
  input  logic [N_OUT*WORD_W-1:0] core_out_data
);
  state_t state, state_d;
  logic [31:0] cnt, cycles, status, bank_rd;
  logic done, err, to, busy, ctrl_wr, start, clear, accept, in_hit, capture, abort, timed_out;
  assign busy = state != IDLE;
  assign ctrl_wr = avs_s0_write && avs_s0_address == CTRL_ADDR;
  assign start = ctrl_wr && avs_s0_writedata[START_BIT];
  assign clear = ctrl_wr && avs_s0_writedata[CLEAR_BIT];
  assign accept = start && !busy;
  assign timed_out = cnt >= 32'(TIMEOUT);
  assign core_in_valid = state == ISSUE;
  network_mmio_regbank #(.N_IN(N_IN), .N_OUT(N_OUT), .WORD_W(WORD_W)) u_bank (
    .clk(clk),
    .reset(reset),
    .addr(avs_s0_address),
    .write(avs_s0_write && !busy),
    .wdata(avs_s0_writedata),
    .capture(capture),
    .cap_data(core_out_data),
    .in_data(core_in_data),
    .rd_data(bank_rd),
    .in_hit(in_hit)
  );
  // Next state: a handshake in the same cycle as the timeout limit wins over the abort.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: state_d = accept ? ISSUE : IDLE;
      ISSUE: begin
        abort = timed_out && !core_in_ready;
        state_d = core_in_ready ? WAIT : abort ? IDLE : ISSUE;
      end
      WAIT: begin
        capture = core_out_valid;
        abort = timed_out && !core_out_valid;
        state_d = (capture || abort) ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // State register.
  always_ff @(posedge clk) state <= reset ? IDLE : state_d;
  // Latency counter: 1 on the first ISSUE cycle, saturating while the run is live.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (accept) cnt <= 32'd1;
    else if (busy) cnt <= sat_inc(cnt);
  end
  // Status flags and the latency of the last completed run.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      err <= 1'b0;
      to <= 1'b0;
      cycles <= '0;
    end else begin
      done <= capture || (done && !abort && !accept && !clear);
      err <= (err && !clear) || (busy && (start || (avs_s0_write && in_hit)));
      to <= abort || (to && !accept);
      if (capture) cycles <= cnt;
    end
  end
  always_comb begin
    status = '0;
    status[BUSY_BIT] = busy;
    status[DONE_BIT] = done;
    status[ERR_BIT] = err;
    status[TO_BIT] = to;
  end
  // Registered read port: data and valid land exactly one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_s0_readdata <= '0;
      avs_s0_readdatavalid <= 1'b0;
    end else begin
      avs_s0_readdatavalid <= avs_s0_read;
      avs_s0_readdata <= !avs_s0_read ? '0 : avs_s0_address == CTRL_ADDR ? status : avs_s0_address == CYCLES_ADDR ? cycles : bank_rd;
    end
  end
endmodule

// File: tb/tb_network_mmio_bridge.sv
// tb_network_mmio_bridge: randomized scoreboard bench against a register-map level model
module tb_network_mmio_bridge;
  localparam int N_IN = 4;
  localparam int N_OUT = 2;
  localparam int WORD_W = 64;
  localparam int TMO = 16;
  localparam int CH = WORD_W / 32;
  localparam int NI = N_IN * CH;
  localparam int NO = N_OUT * CH;
  typedef struct {logic [7:0] a; logic [31:0] d;} exp_t;
  logic clk = 0, reset = 1;
  logic [7:0] avs_s0_address = '0;
  logic avs_s0_read = 0, avs_s0_write = 0;
  logic [31:0] avs_s0_writedata = '0;
  logic [31:0] avs_s0_readdata;
  logic avs_s0_readdatavalid, core_in_valid;
  logic core_in_ready = 0, core_out_valid = 0;
  logic [N_IN*WORD_W-1:0] core_in_data;
  logic [N_OUT*WORD_W-1:0] core_out_data = '0;
  int checks = 0, failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [WORD_W-1:0] m_in [N_IN];
  logic [WORD_W-1:0] m_out [N_OUT];
  logic [31:0] m_cycles;
  logic m_done, m_err, m_to, m_busy;
  network_mmio_bridge #(.N_IN(N_IN), .N_OUT(N_OUT), .WORD_W(WORD_W), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .avs_s0_address(avs_s0_address),
    .avs_s0_read(avs_s0_read),
    .avs_s0_write(avs_s0_write),
    .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_readdata(avs_s0_readdata),
    .avs_s0_readdatavalid(avs_s0_readdatavalid),
    .core_in_valid(core_in_valid),
    .core_in_ready(core_in_ready),
    .core_in_data(core_in_data),
    .core_out_valid(core_out_valid),
    .core_out_data(core_out_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // Monitor: every read response is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (avs_s0_readdatavalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdv_unexpected actual=%h required=none", avs_s0_readdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("read_%02h", mon_e.a), 256'(avs_s0_readdata), 256'(mon_e.d));
      end
    end
  end
  function automatic void model_reset();
    for (int i = 0; i < N_IN; i++) m_in[i] = '0;
    for (int j = 0; j < N_OUT; j++) m_out[j] = '0;
    m_cycles = '0;
    m_done = 0;
    m_err = 0;
    m_to = 0;
    m_busy = 0;
  endfunction
  function automatic logic [31:0] model_read(input logic [7:0] a);
    int o = int'(a) - 16;
    if (a == 8'h00) return {28'd0, m_to, m_err, m_done, m_busy};
    if (a == 8'h01) return m_cycles;
    if (o >= 0 && o < NI) return m_in[o/CH][(o%CH)*32 +: 32];
    if (o >= NI && o < NI + NO) return m_out[(o-NI)/CH][((o-NI)%CH)*32 +: 32];
    return '0;
  endfunction
  function automatic logic [N_IN*WORD_W-1:0] pack_in();
    logic [N_IN*WORD_W-1:0] r = '0;
    for (int i = 0; i < N_IN; i++) r = (r << WORD_W) | (N_IN*WORD_W)'(m_in[i]);
    return r;
  endfunction
  task automatic rd(input logic [7:0] a);
    avs_s0_read = 1;
    avs_s0_address = a;
    exp_q.push_back('{a, model_read(a)});
    @(posedge clk); #1;
    avs_s0_read = 0;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    int o = int'(a) - 16;
    avs_s0_write = 1;
    avs_s0_address = a;
    avs_s0_writedata = d;
    @(posedge clk); #1;
    avs_s0_write = 0;
    if (o >= 0 && o < NI && !m_busy) m_in[o/CH][(o%CH)*32 +: 32] = d;
    if (a == 8'h00 && d[1]) begin m_done = 0; m_err = 0; end
  endtask
  task automatic rd_all();
    rd(8'h00);
    rd(8'h01);
    for (int n = 0; n < NI + NO; n++) rd(8'(16 + $urandom_range(0, NI + NO - 1)));
  endtask
  task automatic start(input bit clr);
    if (clr) m_err = 0;
    m_done = 0;
    m_to = 0;
    avs_s0_write = 1;
    avs_s0_address = 8'h00;
    avs_s0_writedata = clr ? 32'd3 : 32'd1;
    @(posedge clk); #1;
    avs_s0_write = 0;
    m_busy = 1;
  endtask
  // One full run: ready on the ri-th ISSUE cycle, result on the wv-th WAIT cycle.
  task automatic run(input int ri, input int wv, input logic [N_OUT*WORD_W-1:0] res, input bit clr, input bit poke);
    logic [N_IN*WORD_W-1:0] ein = pack_in();
    start(clr);
    for (int c = 1; c <= ri; c++) begin
      core_in_ready = (c == ri);
      @(negedge clk);
      chk("issue_valid", 256'(core_in_valid), 256'(1));
      chk("issue_data", 256'(core_in_data), 256'(ein));
      @(posedge clk); #1;
    end
    core_in_ready = 0;
    for (int c = 1; c <= wv; c++) begin
      core_out_valid = (c == wv);
      core_out_data = res;
      avs_s0_write = poke && (c == 1 || c == 2);
      avs_s0_address = c == 1 ? 8'h00 : 8'h12;
      avs_s0_writedata = c == 1 ? 32'd1 : $urandom;
      @(negedge clk);
      chk("wait_valid", 256'(core_in_valid), 256'(0));
      @(posedge clk); #1;
    end
    avs_s0_write = 0;
    m_busy = 0;
    m_done = 1;
    m_cycles = 32'(ri + wv);
    if (poke) m_err = 1;
    for (int j = 0; j < N_OUT; j++) m_out[j] = res[(N_OUT-1-j)*WORD_W +: WORD_W];
    core_out_valid = 1;
    core_out_data = ~res;
    @(posedge clk); #1;
    core_out_valid = 0;
  endtask
  initial begin
    int n;
    logic [N_OUT*WORD_W-1:0] res;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    rd(8'h00);
    rd(8'h01);
    rd(8'h10);
    rd(8'h18);
    rd(8'hFF);
    @(posedge clk); #1;
    avs_s0_read = 1;
    avs_s0_address = 8'h00;
    exp_q.push_back('{8'h00, model_read(8'h00)});
    @(negedge clk);
    chk("rdv_same_cycle", 256'(avs_s0_readdatavalid), 256'(0));
    @(posedge clk); #1;
    avs_s0_read = 0;
    @(negedge clk);
    chk("rdv_next_cycle", 256'(avs_s0_readdatavalid), 256'(1));
    @(negedge clk);
    chk("rdv_after", 256'(avs_s0_readdatavalid), 256'(0));
    @(posedge clk); #1;
    wr(8'h10, 32'h11111111);
    wr(8'h11, 32'h22222222);
    for (int a = 8'h12; a < 16 + NI; a++) wr(8'(a), $urandom);
    wr(8'h01, $urandom);
    wr(8'h18, $urandom);
    wr(8'h1C, $urandom);
    for (int a = 8'h10; a < 16 + NI + NO + 1; a++) rd(8'(a));
    chk("word0_in", 256'(core_in_data[N_IN*WORD_W-1 -: WORD_W]), 256'(64'h2222222211111111));
    res = {64'hDEADBEEF_CAFEF00D, 32'($urandom), 32'($urandom)};
    run(3, 5, res, 0, 0);
    rd(8'h18);
    rd(8'h19);
    rd(8'h00);
    rd(8'h01);
    chk("model_cycles", 256'(m_cycles), 256'(8));
    run(2, 4, {$urandom, $urandom, $urandom, $urandom}, 0, 1);
    rd(8'h00);
    rd(8'h12);
    rd_all();
    wr(8'h00, 32'd2);
    rd(8'h00);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 3; k++) wr(8'(16 + $urandom_range(0, NI - 1)), $urandom);
      run($urandom_range(1, 4), $urandom_range(1, 6), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 0);
      rd_all();
    end
    start(0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!core_in_valid) break;
      n++;
    end
    chk("timeout_len", 256'(n), 256'(TMO));
    @(posedge clk); #1;
    m_busy = 0;
    m_to = 1;
    m_done = 0;
    rd(8'h00);
    for (int a = 16 + NI; a < 16 + NI + NO; a++) rd(8'(a));
    rd(8'h01);
    run(1, 1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    rd(8'h00);
    for (int a = 8'h10; a < 16 + NI; a++) wr(8'(a), $urandom);
    start(0);
    core_in_ready = 1;
    @(posedge clk); #1;
    core_in_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    core_out_valid = 1;
    core_out_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    core_out_valid = 0;
    chk("reset_in_valid", 256'(core_in_valid), 256'(0));
    rd(8'h00);
    rd(8'h01);
    for (int a = 8'h10; a < 16 + NI + NO; a++) rd(8'(a));
    rd(8'hFF);
    rd(8'h05);
    rd(8'(16 + NI + NO));
    repeat (3) @(posedge clk);
    chk("pending_reads", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/network_mmio_bridge.md
NETWORK_MMIO_BRIDGE -- requirements
Module: network_mmio_bridge

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning number of input operand words.
REQ-002 SHALL have parameter N_OUT, default 2, meaning number of result words.
REQ-003 SHALL have parameter WORD_W, default 64, meaning operand/result width; legal values are multiples of 32.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles to wait for the core before aborting.
REQ-005 SHALL have port clk, input, 1, the clock; reset reset, synchronous, active-high; clock clk.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port avs_s0_address, input, 8, word address.
REQ-008 SHALL have port avs_s0_read, input, 1, read strobe.
REQ-009 SHALL have port avs_s0_write, input, 1, write strobe.
REQ-010 SHALL have port avs_s0_writedata, input, 32, write data.
REQ-011 SHALL have port avs_s0_readdata, output, 32, registered read data.
REQ-012 SHALL have port avs_s0_readdatavalid, output, 1, pulses with readdata.
REQ-013 SHALL have port core_in_valid, output, 1, operand bundle valid.
REQ-014 SHALL have port core_in_ready, input, 1, core accepts the bundle.
REQ-015 SHALL have port core_in_data, output, N_IN*WORD_W, operands, word 0 in the MSBs.
REQ-016 SHALL have port core_out_valid, input, 1, one-cycle result strobe.
REQ-017 SHALL have port core_out_data, input, N_OUT*WORD_W, results, word 0 in the MSBs.

Function
REQ-018 SHALL define CH = WORD_W/32 chunks per word, with chunk 0 being the least-significant 32 bits.
REQ-019 SHALL implement the register map:
- 0x00 CTRL/STATUS: write bit0 = start, bit1 = clear_done; read bit0 = busy, bit1 = done, bit2 = err, bit3 = timeout.
- 0x01 CYCLES: read-only, core latency of the last run.
- 0x10 + i*CH + k: input word i, chunk k, read/write.
- 0x10 + N_IN*CH + j*CH + k: output word j, chunk k, read-only.
REQ-020 SHALL register every read: readdata and readdatavalid=1 appear exactly one cycle after avs_s0_read; readdatavalid=0 otherwise; unmapped addresses read 0.
REQ-021 SHALL ignore writes to read-only or unmapped addresses.
REQ-022 SHALL implement FSM states IDLE, ISSUE and WAIT.
- IDLE --start--> ISSUE.
- ISSUE --core_in_ready--> WAIT.
- WAIT --core_out_valid--> IDLE.
- ISSUE or WAIT --cycle count reaches TIMEOUT--> IDLE.
REQ-023 SHALL hold core_in_valid=1 and core_in_data stable for exactly the ISSUE state.
REQ-024 SHALL report busy=1 in ISSUE and WAIT.
REQ-025 SHALL, on core_out_valid in WAIT, capture core_out_data into the output registers, set done=1 and load CYCLES.
REQ-026 SHALL hold the output registers unchanged until the next capture.
REQ-027 SHALL ignore core_out_valid outside WAIT.
REQ-028 SHALL count CYCLES from the first ISSUE cycle (value 1) through the core_out_valid cycle inclusive, with a 32-bit saturating counter.
REQ-029 SHALL, on reaching TIMEOUT cycles, return to IDLE with timeout=1 and done=0, leaving the output registers unchanged.
REQ-030 SHALL clear done and timeout on an accepted start.
REQ-031 SHALL, when start and clear_done arrive in one write, clear done first and then start.
REQ-032 SHALL, while busy, ignore start and writes to input registers and set err=1 instead.
REQ-033 SHALL clear err only through a clear_done write.
REQ-034 SHALL return the stored input value on reads of input registers.

Reset
REQ-035 SHALL, on reset, set the FSM to IDLE, clear all input, output, CYCLES and status registers to 0, and drive readdata=0, readdatavalid=0 and core_in_valid=0.
REQ-036 SHALL, on reset mid-run, abandon the run and ignore a later core_out_valid.

Structure
REQ-037 SHALL place the state enum, register offsets (CTRL=0x00, CYCLES=0x01, IN_BASE=0x10) and status bit positions in package network_mmio_pkg.
REQ-038 SHALL instantiate one sub-module, network_mmio_regbank, holding the chunked input/output word storage and read mux; the FSM stays in the top.

Verification
REQ-039 SHALL cover: N_IN=4, WORD_W=64; write 0x10 = 0x11111111 and 0x11 = 0x22222222 -> core_in_data word 0 = 0x2222222211111111 during ISSUE.
REQ-040 SHALL cover: start, core_in_ready after 2 cycles, core_out_valid 5 cycles later with word 0 = 0xDEADBEEF_CAFEF00D -> read of 0x18 returns 0xCAFEF00D, 0x19 returns 0xDEADBEEF, STATUS = 0x2, CYCLES = 8.
REQ-041 SHALL cover: start while busy, then a write to 0x12 -> err=1, operand unchanged, the run completes normally.
REQ-042 SHALL cover: TIMEOUT=16 with the core never responding -> IDLE after 16 cycles, STATUS = 0x8, output registers keep prior values.
REQ-043 SHALL cover: reset asserted in WAIT, then core_out_valid -> STATUS = 0, outputs = 0, no capture.
REQ-044 SHALL cover: a read of 0x00 on cycle t -> readdatavalid=1 only on cycle t+1; a read of 0xFF -> 0.
